// File: rtl/bram_pkg.sv
// bram_pkg: reader FSM encoding and the clogb2 sizing helper shared with block_ram_simple_dual_port
package bram_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
  function automatic int clogb2(input int depth);
    int r = 0;
    for (int d = depth; d > 0; d = d >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: two-entry registered FIFO, head always presented on dout
module skid_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);
  logic [W-1:0] r_mem0, r_mem1;
  logic [1:0]   r_count;
  // entry 0 is the head; entry 1 shifts down on pop, new data lands in the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= '0;
    end else begin
      r_count <= r_count + {1'b0, push} - {1'b0, pop};
      if (pop && r_count == 2'd2) r_mem0 <= r_mem1;
      else if (push && r_count == (pop ? 2'd1 : 2'd0)) r_mem0 <= din;
      if (push && r_count == (pop ? 2'd2 : 2'd1)) r_mem1 <= din;
    end
  end
  assign dout  = r_mem0;
  assign count = r_count;
  assign empty = (r_count == 2'd0);
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: fetches len words from base in a registered-read BRAM and streams them out valid/ready; BRAM_READER_LAST_EN adds m_last
module bram_stream_reader
  import bram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DATA_DEPTH = 256,
  localparam int ADDR_WIDTH = clogb2(DATA_DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_enb,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef BRAM_READER_LAST_EN
  output logic                  m_last,
`endif
  output logic                  busy,
  output logic                  done
);
`ifdef BRAM_READER_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len, r_issued, w_len_clamped;
  logic                  r_inflight;
  logic                  w_accept, w_pop, w_issue, w_last_issue, w_empty;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;
  logic [FW-1:0]         w_din, w_dout;
  assign w_accept      = cmd_valid && (r_state == IDLE);
  assign w_len_clamped = (cmd_len > LEN_WIDTH'(DATA_DEPTH)) ? LEN_WIDTH'(DATA_DEPTH) : cmd_len;
  assign w_pop         = m_valid && m_ready;
  assign w_occ         = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue       = (r_state == READ) && (r_issued < r_len) && (w_occ < 3'd2);
  assign w_last_issue  = w_issue && (r_issued == r_len - 1'b1);
  assign ram_enb       = w_issue;
  assign ram_addrb     = r_addr;
  assign m_valid       = !w_empty;
  assign m_data        = w_dout[DATA_WIDTH-1:0];
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state and status outputs; DRAIN exits once nothing is left after this cycle's pop
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_next = (w_len_clamped == '0) ? DONE : READ;
      end
      READ:  if (w_last_issue) w_next = DRAIN;
      DRAIN: if (w_occ == 3'd0) w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
    endcase
  end
  // command latch, read address with explicit wrap, issue count and in-flight flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr   <= cmd_base;
        r_len    <= w_len_clamped;
        r_issued <= '0;
      end else if (w_issue) begin
        r_addr   <= (r_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0 : r_addr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
    end
  end
`ifdef BRAM_READER_LAST_EN
  logic r_inflight_last;
  // last flag travels with its read so it lands in the FIFO beside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight_last <= 1'b0;
    else r_inflight_last <= w_last_issue;
  end
  assign w_din  = {r_inflight_last, ram_doutb};
  assign m_last = m_valid && w_dout[DATA_WIDTH];
`else
  assign w_din = ram_doutb;
`endif
  skid_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .count (w_count),
    .empty (w_empty)
  );
endmodule
